image_row_packer: RTL and testbench

- Upstream feeder for the image banks: packs a stream of 32-bit pixel words into full 3072-bit rows and issues one-cycle row writes (we/waddr/wdata/idx) to a selected image bank.
- Sits between the CPU/DMA word path and the three image banks; one packer is shared by all banks via the idx output.
- Handles a multi-row transfer (base row, row count, target bank) per start command, with valid/ready input flow control.

---
 rtl/image_pkg.sv | 18 +
 rtl/image_row_packer_row_reg.sv | 27 ++
 rtl/image_row_packer.sv | 144 ++++++++++++++
 tb/tb_image_row_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants and packer state type for the image bank subsystem
// (banks, row packer and coprocessor).
package image_pkg;

    localparam int WORD_W    = 32;
    localparam int ROW_W     = 3072;
    localparam int DEPTH     = 64;
    localparam int ADDR_W    = 7;
    localparam int NUM_BANKS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/image_row_packer_row_reg.sv
// Word-indexed row register: stores one input word into its slot of a
// WPR-word row, word 0 at the least significant bits.
module row_shift_reg #(
    parameter int WORD_W = 32,
    parameter int WPR    = 96,
    parameter int IDX_W  = $clog2(WPR)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load_en,
    input  logic [IDX_W-1:0]        word_idx,
    input  logic [WORD_W-1:0]       word_in,
    output logic [WPR*WORD_W-1:0]   row
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if (clear) begin
            row <= '0;
        end else if (load_en) begin
            row[word_idx*WORD_W +: WORD_W] <= word_in;
        end
    end

endmodule

// File: rtl/image_row_packer.sv
// Packs a stream of input words into full rows and issues one-cycle row
// writes to the selected image bank, for a multi-row transfer per start.
module image_row_packer #(
    parameter int WORD_W = image_pkg::WORD_W,
    parameter int ROW_W  = image_pkg::ROW_W,
    parameter int DEPTH  = image_pkg::DEPTH,
    parameter int ADDR_W = image_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_row,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [1:0]        bank_sel,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ROW_W-1:0]  wdata,
    output logic [1:0]        idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import image_pkg::packer_state_t;
    import image_pkg::IDLE;
    import image_pkg::FILL;
    import image_pkg::WRITE;
    import image_pkg::DONE;
    import image_pkg::NUM_BANKS;

    localparam int WPR   = ROW_W / WORD_W;
    localparam int CNT_W = $clog2(WPR);

    packer_state_t     state, next_state;
    logic [CNT_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] row_cnt;
    logic [ADDR_W-1:0] base_lat;
    logic [ADDR_W-1:0] rows_lat;
    logic              accept;
    logic              last_word;
    logic              last_row;
    logic              cmd_take;
    logic              bad_bank;

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [ADDR_W-1:0] r);
        logic [ADDR_W:0] sum;
        sum = {1'b0, b} + {1'b0, r};
        return ADDR_W'(sum % (ADDR_W+1)'(DEPTH));
    endfunction

    function automatic logic [ADDR_W-1:0] sat_rows(input logic [ADDR_W-1:0] n);
        return (n > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : n;
    endfunction

    // in_ready is a registered decode of FILL, so it qualifies the handshake directly
    assign accept    = in_ready && in_valid;
    assign last_word = (word_cnt == CNT_W'(WPR - 1));
    assign last_row  = ((row_cnt + ADDR_W'(1)) >= rows_lat);
    assign cmd_take  = (state == IDLE) && start;
    assign bad_bank  = (bank_sel >= 2'(NUM_BANKS));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_bank || num_rows == '0) next_state = DONE;
                    else                            next_state = FILL;
                end
            end
            FILL: begin
                if (abort)                       next_state = DONE;
                else if (accept && last_word)    next_state = WRITE;
            end
            WRITE:   next_state = (abort || last_row) ? DONE : FILL;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we       <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            waddr    <= '0;
            word_cnt <= '0;
            row_cnt  <= '0;
            base_lat <= '0;
            rows_lat <= '0;
        end else begin
            state    <= next_state;
            we       <= (next_state == WRITE);
            done     <= (next_state == DONE);
            in_ready <= (next_state == FILL);
            busy     <= (next_state != IDLE);

            if (cmd_take) begin
                base_lat <= base_row;
                rows_lat <= sat_rows(num_rows);
                idx      <= bank_sel;
                err      <= bad_bank;
                row_cnt  <= '0;
                word_cnt <= '0;
            end

            if (accept) begin
                word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
            end

            if (state == WRITE) begin
                row_cnt <= row_cnt + ADDR_W'(1);
            end

            // Address is captured once on entry to WRITE so it is steady for the strobe
            if (next_state == WRITE) begin
                waddr <= wrap_addr(base_lat, row_cnt);
            end
        end
    end

    row_shift_reg #(
        .WORD_W (WORD_W),
        .WPR    (WPR),
        .IDX_W  (CNT_W)
    ) u_row (
        .clk      (clk),
        .rst      (rst),
        .clear    (cmd_take),
        .load_en  (accept),
        .word_idx (word_cnt),
        .word_in  (in_data),
        .row      (wdata)
    );

endmodule

// File: tb/tb_image_row_packer.sv
// Scoreboard bench for image_row_packer: expected row writes are queued at
// stimulus time and compared against every we strobe.
module tb_image_row_packer;

    localparam int WORD_W = 32;
    localparam int ROW_W  = 3072;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 7;
    localparam int WPR    = ROW_W / WORD_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        bank;
        logic [ROW_W-1:0]  data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_row = '0;
    logic [ADDR_W-1:0] num_rows = '0;
    logic [1:0]        bank_sel = '0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ROW_W-1:0]  wdata;
    logic [1:0]        idx;
    logic              busy;
    logic              done;
    logic              err;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  we_cyc = 0;
    int  done_cyc = 0;
    int  first_acc = 0;
    int  last_acc = 0;
    wr_t sb[$];

    image_row_packer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_row (base_row),
        .num_rows (num_rows),
        .bank_sel (bank_sel),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input int seed);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < WPR; k++) r[k*WORD_W +: WORD_W] = 32'(seed * 65536 + k);
        return r;
    endfunction

    task automatic push_wr(input int addr, input int bank, input int seed);
        wr_t e;
        e.addr = ADDR_W'(addr % DEPTH);
        e.bank = 2'(bank);
        e.data = mk_row(seed);
        sb.push_back(e);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin : mon
        wr_t e;
        int  k;
        bit  found;
        if (!rst) begin
            if (!busy) chk("rdy_idle", 64'(in_ready), 64'(0));
            if (done)  chk("rdy_done", 64'(in_ready), 64'(0));
            if (we) begin
                wr_cnt <= wr_cnt + 1;
                we_cyc <= cyc;
                chk("rdy_write", 64'(in_ready), 64'(0));
                if (sb.size() == 0) begin
                    chk("unexpected_we", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("waddr", 64'(waddr), 64'(e.addr));
                    chk("idx", 64'(idx), 64'(e.bank));
                    k = 0;
                    found = 1'b0;
                    for (int j = 0; j < WPR; j++) begin
                        if (!found && wdata[j*WORD_W +: WORD_W] !== e.data[j*WORD_W +: WORD_W]) begin
                            k = j;
                            found = 1'b1;
                        end
                    end
                    chk($sformatf("wdata_w%0d", k), 64'(wdata[k*WORD_W +: WORD_W]),
                        64'(e.data[k*WORD_W +: WORD_W]));
                end
            end
        end
    end

    task automatic do_start(input int b, input int n, input int bank);
        @(posedge clk); #1;
        start    = 1'b1;
        base_row = ADDR_W'(b);
        num_rows = ADDR_W'(n);
        bank_sel = 2'(bank);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input bit rnd);
        int guard;
        guard = 0;
        if (rnd) begin
            while ($urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            chk("hs_timeout", 64'(guard), 64'(0));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_row(input int seed, input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            send_word(32'(seed * 65536 + k), rnd);
            if (k == 0) first_acc = last_acc;
        end
    endtask

    task automatic wait_done(input bit exp_err);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("err", 64'(err), 64'(exp_err));
        @(negedge clk);
        chk("busy_drop", 64'(busy), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_wdata", 64'(|wdata), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // single row, full-rate input
        w0 = wr_cnt;
        push_wr(5, 1, 0);
        do_start(5, 1, 1);
        send_row(0, WPR, 1'b0);
        wait_done(1'b0);
        chk("we_latency", 64'(we_cyc - first_acc), 64'(95));
        chk("done_after_we", 64'(done_cyc - we_cyc), 64'(1));
        chk("single_writes", 64'(wr_cnt - w0), 64'(1));

        // address wrap
        w0 = wr_cnt;
        for (int r = 0; r < 4; r++) push_wr(62 + r, 2, 1 + r);
        do_start(62, 4, 2);
        for (int r = 0; r < 4; r++) send_row(1 + r, WPR, 1'b0);
        wait_done(1'b0);
        chk("wrap_writes", 64'(wr_cnt - w0), 64'(4));

        // backpressure gives the same row as the no-stall run
        push_wr(10, 0, 0);
        do_start(10, 1, 0);
        send_row(0, WPR, 1'b1);
        wait_done(1'b0);

        // abort midway through the second row of three
        w0 = wr_cnt;
        push_wr(20, 1, 10);
        do_start(20, 3, 1);
        send_row(10, WPR, 1'b0);
        send_row(11, 40, 1'b0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done(1'b0);
        chk("abort_writes", 64'(wr_cnt - w0), 64'(1));
        push_wr(30, 0, 12);
        do_start(30, 1, 0);
        send_row(12, WPR, 1'b0);
        wait_done(1'b0);

        // illegal bank, then zero rows
        w0 = wr_cnt;
        do_start(0, 1, 3);
        wait_done(1'b1);
        do_start(0, 0, 0);
        wait_done(1'b0);
        chk("illegal_zero_writes", 64'(wr_cnt - w0), 64'(0));

        // row count above DEPTH saturates
        w0 = wr_cnt;
        for (int r = 0; r < DEPTH; r++) push_wr(3 + r, 2, 100 + r);
        do_start(3, 127, 2);
        for (int r = 0; r < DEPTH; r++) send_row(100 + r, WPR, 1'b0);
        wait_done(1'b0);
        chk("sat_writes", 64'(wr_cnt - w0), 64'(DEPTH));

        // asynchronous reset mid-row
        w0 = wr_cnt;
        do_start(40, 1, 2);
        send_row(50, 50, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 64'(we), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_idx", 64'(idx), 64'(0));
        chk("arst_wdata", 64'(|wdata), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("arst_writes", 64'(wr_cnt - w0), 64'(0));
        push_wr(41, 1, 60);
        do_start(41, 1, 1);
        send_row(60, WPR, 1'b0);
        wait_done(1'b0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
